// File: rtl/datapath_pkg.sv
// Shared state encoding and width helpers for the matrix-job datapath sequencer.
package datapath_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_X = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    // Width of a row/col/index value in 0..max_dim-1 (never narrower than one bit).
    function automatic int idx_width(input int max_dim);
        return (max_dim <= 1) ? 1 : $clog2(max_dim);
    endfunction

    // Width able to hold the dimension itself, 0..max_dim.
    function automatic int dim_width(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

endpackage

// File: rtl/buf_read_streamer.sv
// Issues a run of sequential buffer reads and tracks their returns; one instance per read buffer.
module buf_read_streamer #(
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 8,
    parameter int BASE_W     = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              restart,
    input  logic              issue_en,
    input  logic [CNT_W-1:0]  total,
    input  logic [BASE_W-1:0] base,
    input  logic              rd_valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              ret_fire,
    output logic [CNT_W-1:0]  ret_cnt
);

    logic [CNT_W-1:0]      issue_q, issue_d;
    logic [CNT_W-1:0]      ret_q, ret_d;
    logic [RD_LATENCY-1:0] pend_q, pend_d;
    logic                  rd_en_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic                  issue;
    logic [BASE_W:0]       full_addr;

    assign issue     = issue_en && !clear && !restart && (issue_q < total);
    assign full_addr = {1'b0, base} + (BASE_W + 1)'(issue_q);
    // A return is only believed when a request issued RD_LATENCY cycles ago is due.
    assign ret_fire  = rd_valid && pend_q[RD_LATENCY-1] && !clear;
    assign pend_d    = RD_LATENCY'({pend_q, rd_en_q});

    always_comb begin
        issue_d = issue_q;
        ret_d   = ret_q;
        if (clear || restart) begin
            issue_d = '0;
            ret_d   = '0;
        end else begin
            if (issue)    issue_d = issue_q + 1'b1;
            if (ret_fire) ret_d   = ret_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q   <= '0;
            ret_q     <= '0;
            pend_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            issue_q <= issue_d;
            ret_q   <= ret_d;
            pend_q  <= clear ? '0 : pend_d;
            rd_en_q <= issue;
            if (issue) rd_addr_q <= ADDR_W'(full_addr);
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign ret_cnt = ret_q;

endmodule

// File: rtl/datapath_sequencer.sv
// Sequences one NxN job: preload N*N weights into the MMU, then per row stream N inputs
// and drain N activation beats into the output buffer.
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int MAX_DIM           = 8,
    parameter int INPUT_ADDR_WIDTH  = 8,
    parameter int WEIGHT_ADDR_WIDTH = 10,
    parameter int OUTPUT_ADDR_WIDTH = 8,
    parameter int RD_LATENCY        = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             clear,
    input  logic [7:0]                       dim,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             input_buf_rd_en,
    output logic [INPUT_ADDR_WIDTH-1:0]      input_buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]            input_buf_rd_data,
    input  logic                             input_buf_rd_valid,
    output logic                             weight_buf_rd_en,
    output logic [WEIGHT_ADDR_WIDTH-1:0]     weight_buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]            weight_buf_rd_data,
    input  logic                             weight_buf_rd_valid,
    output logic                             output_buf_wr_en,
    output logic [OUTPUT_ADDR_WIDTH-1:0]     output_buf_wr_addr,
    output logic [DATA_WIDTH-1:0]            output_buf_wr_data,
    output logic [DATA_WIDTH-1:0]            mmu_weight_data,
    output logic [idx_width(MAX_DIM)-1:0]    mmu_weight_row,
    output logic [idx_width(MAX_DIM)-1:0]    mmu_weight_col,
    output logic                             mmu_weight_valid,
    output logic [DATA_WIDTH-1:0]            mmu_input_data,
    output logic [idx_width(MAX_DIM)-1:0]    mmu_input_index,
    output logic                             mmu_input_valid,
    input  logic [DATA_WIDTH-1:0]            act_output_data,
    input  logic                             act_output_valid
);

    localparam int IW = idx_width(MAX_DIM);
    localparam int DW = dim_width(MAX_DIM);
    localparam int CW = 2 * DW;
    localparam int FW = 2 * DW + 1;

    state_e state_q, state_d;

    logic [DW-1:0] n_q;
    logic [IW-1:0] row_q, beat_q, wrow_q, wcol_q;
    logic [CW-1:0] w_total, x_total, w_ret, x_ret;
    logic [FW-1:0] x_base, out_addr_full;
    logic          dim_ok, w_restart, x_restart, w_fire, x_fire, act_fire;
    logic          w_done, x_done, last_beat, last_row, last_wcol, err_d;

    logic                         mmu_w_valid_q, mmu_x_valid_q, wr_en_q, error_q;
    logic [DATA_WIDTH-1:0]        mmu_w_data_q, mmu_x_data_q, wr_data_q;
    logic [IW-1:0]                mmu_w_row_q, mmu_w_col_q, mmu_x_index_q;
    logic [OUTPUT_ADDR_WIDTH-1:0] wr_addr_q;

    assign dim_ok    = (dim != 8'd0) && (int'(dim) <= MAX_DIM);
    // Products are formed at full width before any truncation to port widths.
    assign w_total       = CW'(n_q) * CW'(n_q);
    assign x_total       = CW'(n_q);
    assign x_base        = FW'(row_q) * FW'(n_q);
    assign out_addr_full = x_base + FW'(beat_q);

    assign w_done    = (w_ret == w_total);
    assign x_done    = (x_ret == x_total);
    assign last_beat = (DW'(beat_q) == n_q - DW'(1));
    assign last_row  = (DW'(row_q)  == n_q - DW'(1));
    assign last_wcol = (DW'(wcol_q) == n_q - DW'(1));
    assign act_fire  = act_output_valid && (state_q == S_DRAIN) && !clear;
    assign err_d     = !clear && (((state_q == S_IDLE) && start && !dim_ok) ||
                                  (act_output_valid && (state_q != S_DRAIN)));
    assign w_restart = (state_d == S_LOAD_W) && (state_q != S_LOAD_W);
    assign x_restart = (state_d == S_LOAD_X) && (state_q != S_LOAD_X);

    buf_read_streamer #(
        .CNT_W(CW), .ADDR_W(WEIGHT_ADDR_WIDTH), .BASE_W(FW), .RD_LATENCY(RD_LATENCY)
    ) u_w_stream (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .restart  (w_restart),
        .issue_en (state_q == S_LOAD_W),
        .total    (w_total),
        .base     ('0),
        .rd_valid (weight_buf_rd_valid),
        .rd_en    (weight_buf_rd_en),
        .rd_addr  (weight_buf_rd_addr),
        .ret_fire (w_fire),
        .ret_cnt  (w_ret)
    );

    buf_read_streamer #(
        .CNT_W(CW), .ADDR_W(INPUT_ADDR_WIDTH), .BASE_W(FW), .RD_LATENCY(RD_LATENCY)
    ) u_x_stream (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .restart  (x_restart),
        .issue_en (state_q == S_LOAD_X),
        .total    (x_total),
        .base     (x_base),
        .rd_valid (input_buf_rd_valid),
        .rd_en    (input_buf_rd_en),
        .rd_addr  (input_buf_rd_addr),
        .ret_fire (x_fire),
        .ret_cnt  (x_ret)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start && dim_ok) state_d = S_LOAD_W;
                S_LOAD_W: if (w_done) state_d = S_LOAD_X;
                S_LOAD_X: if (x_done) state_d = S_DRAIN;
                S_DRAIN:  if (act_fire && last_beat) state_d = last_row ? S_FINISH : S_LOAD_X;
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_LOAD_W, S_LOAD_X, S_DRAIN: busy = 1'b1;
            S_FINISH:                    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q           <= '0;
            row_q         <= '0;
            beat_q        <= '0;
            wrow_q        <= '0;
            wcol_q        <= '0;
            mmu_w_valid_q <= 1'b0;
            mmu_x_valid_q <= 1'b0;
            wr_en_q       <= 1'b0;
            error_q       <= 1'b0;
            mmu_w_data_q  <= '0;
            mmu_w_row_q   <= '0;
            mmu_w_col_q   <= '0;
            mmu_x_data_q  <= '0;
            mmu_x_index_q <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            mmu_w_valid_q <= w_fire;
            mmu_x_valid_q <= x_fire;
            wr_en_q       <= act_fire;
            error_q       <= err_d;
            if (clear) begin
                row_q  <= '0;
                beat_q <= '0;
                wrow_q <= '0;
                wcol_q <= '0;
            end else begin
                if ((state_q == S_IDLE) && start && dim_ok) begin
                    n_q    <= DW'(dim);
                    row_q  <= '0;
                    beat_q <= '0;
                end
                // Row/col of a weight beat follow returns, not requests.
                if (w_restart) begin
                    wrow_q <= '0;
                    wcol_q <= '0;
                end else if (w_fire) begin
                    if (last_wcol) begin
                        wcol_q <= '0;
                        wrow_q <= wrow_q + 1'b1;
                    end else begin
                        wcol_q <= wcol_q + 1'b1;
                    end
                end
                if (act_fire) begin
                    beat_q <= last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat && !last_row) row_q <= row_q + 1'b1;
                end
            end
            if (w_fire) begin
                mmu_w_data_q <= weight_buf_rd_data;
                mmu_w_row_q  <= wrow_q;
                mmu_w_col_q  <= wcol_q;
            end
            if (x_fire) begin
                mmu_x_data_q  <= input_buf_rd_data;
                mmu_x_index_q <= IW'(x_ret);
            end
            if (act_fire) begin
                wr_addr_q <= OUTPUT_ADDR_WIDTH'(out_addr_full);
                wr_data_q <= act_output_data;
            end
        end
    end

    assign error              = error_q;
    assign mmu_weight_valid   = mmu_w_valid_q;
    assign mmu_weight_data    = mmu_w_data_q;
    assign mmu_weight_row     = mmu_w_row_q;
    assign mmu_weight_col     = mmu_w_col_q;
    assign mmu_input_valid    = mmu_x_valid_q;
    assign mmu_input_data     = mmu_x_data_q;
    assign mmu_input_index    = mmu_x_index_q;
    assign output_buf_wr_en   = wr_en_q;
    assign output_buf_wr_addr = wr_addr_q;
    assign output_buf_wr_data = wr_data_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: latency-accurate buffer models, an echoing activation
// responder, and a job-level model of the expected beat/address streams.
`timescale 1ns/1ps
module tb_datapath_sequencer;

    localparam int DW  = 16;
    localparam int MD  = 8;
    localparam int IAW = 8;
    localparam int WAW = 10;
    localparam int OAW = 8;
    localparam int RDL = 3;
    localparam int IW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, clear = 1'b0;
    logic [7:0] dim = 8'd0;
    logic busy, done, error;
    logic input_buf_rd_en, weight_buf_rd_en, output_buf_wr_en;
    logic [IAW-1:0] input_buf_rd_addr;
    logic [WAW-1:0] weight_buf_rd_addr;
    logic [OAW-1:0] output_buf_wr_addr;
    logic [DW-1:0]  input_buf_rd_data, weight_buf_rd_data, output_buf_wr_data;
    logic           input_buf_rd_valid, weight_buf_rd_valid;
    logic [DW-1:0]  mmu_weight_data, mmu_input_data, act_output_data;
    logic [IW-1:0]  mmu_weight_row, mmu_weight_col, mmu_input_index;
    logic           mmu_weight_valid, mmu_input_valid, act_output_valid;

    always #5 clk = ~clk;

    datapath_sequencer #(
        .DATA_WIDTH(DW), .MAX_DIM(MD), .INPUT_ADDR_WIDTH(IAW),
        .WEIGHT_ADDR_WIDTH(WAW), .OUTPUT_ADDR_WIDTH(OAW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .dim(dim),
        .busy(busy), .done(done), .error(error),
        .input_buf_rd_en(input_buf_rd_en), .input_buf_rd_addr(input_buf_rd_addr),
        .input_buf_rd_data(input_buf_rd_data), .input_buf_rd_valid(input_buf_rd_valid),
        .weight_buf_rd_en(weight_buf_rd_en), .weight_buf_rd_addr(weight_buf_rd_addr),
        .weight_buf_rd_data(weight_buf_rd_data), .weight_buf_rd_valid(weight_buf_rd_valid),
        .output_buf_wr_en(output_buf_wr_en), .output_buf_wr_addr(output_buf_wr_addr),
        .output_buf_wr_data(output_buf_wr_data),
        .mmu_weight_data(mmu_weight_data), .mmu_weight_row(mmu_weight_row),
        .mmu_weight_col(mmu_weight_col), .mmu_weight_valid(mmu_weight_valid),
        .mmu_input_data(mmu_input_data), .mmu_input_index(mmu_input_index),
        .mmu_input_valid(mmu_input_valid),
        .act_output_data(act_output_data), .act_output_valid(act_output_valid)
    );

    // Buffer models: a read issued at one edge returns RDL edges later.
    logic [DW-1:0]  wmem [0:1023];
    logic [DW-1:0]  imem [0:255];
    logic [RDL-1:0] wv_p = '0, iv_p = '0;
    logic [WAW-1:0] wa_p [RDL];
    logic [IAW-1:0] ia_p [RDL];
    logic inj_wv = 1'b0, inj_iv = 1'b0;

    initial for (int s = 0; s < RDL; s++) begin wa_p[s] = '0; ia_p[s] = '0; end

    always @(posedge clk) begin
        wv_p    <= {wv_p[RDL-2:0], weight_buf_rd_en};
        iv_p    <= {iv_p[RDL-2:0], input_buf_rd_en};
        wa_p[0] <= weight_buf_rd_addr;
        ia_p[0] <= input_buf_rd_addr;
        for (int s = 1; s < RDL; s++) begin
            wa_p[s] <= wa_p[s-1];
            ia_p[s] <= ia_p[s-1];
        end
    end

    assign weight_buf_rd_valid = wv_p[RDL-1] | inj_wv;
    assign weight_buf_rd_data  = wmem[wa_p[RDL-1]];
    assign input_buf_rd_valid  = iv_p[RDL-1] | inj_iv;
    assign input_buf_rd_data   = imem[ia_p[RDL-1]];

    // Activation responder: after every N input beats, return N random result beats.
    int            n_tb = 1;
    bit            resp_en = 1'b0;
    logic          resp_v = 1'b0;
    logic [DW-1:0] resp_d = '0;
    int            r_pend = 0, r_xin = 0;
    logic [DW-1:0] r_val;
    logic [DW-1:0] act_sent [$];
    logic          inj_act = 1'b0;
    logic [DW-1:0] inj_d = '0;

    always @(posedge clk) begin
        if (!resp_en) begin
            r_pend = 0;
            r_xin  = 0;
            resp_v <= 1'b0;
        end else begin
            if (mmu_input_valid === 1'b1) begin
                r_xin++;
                if (r_xin == n_tb) begin
                    r_xin = 0;
                    r_pend += n_tb;
                end
            end
            if (r_pend > 0 && $urandom_range(0, 3) != 0) begin
                r_val = DW'($urandom);
                act_sent.push_back(r_val);
                resp_v <= 1'b1;
                resp_d <= r_val;
                r_pend--;
            end else begin
                resp_v <= 1'b0;
            end
        end
    end

    assign act_output_valid = resp_v | inj_act;
    assign act_output_data  = inj_act ? inj_d : resp_d;

    // Monitor: record every qualified beat away from the active edge.
    logic [WAW-1:0] waddr_q [$];
    logic [IAW-1:0] iaddr_q [$];
    logic [DW-1:0]  wb_data [$], xb_data [$], wr_data [$];
    logic [IW-1:0]  wb_row [$], wb_col [$], xb_idx [$];
    logic [OAW-1:0] wr_addr [$];
    int done_cnt = 0, err_cnt = 0, busy_cnt = 0, rd_cnt = 0;

    always @(negedge clk) begin
        if (weight_buf_rd_en === 1'b1) begin waddr_q.push_back(weight_buf_rd_addr); rd_cnt++; end
        if (input_buf_rd_en === 1'b1)  begin iaddr_q.push_back(input_buf_rd_addr); rd_cnt++; end
        if (mmu_weight_valid === 1'b1) begin
            wb_data.push_back(mmu_weight_data);
            wb_row.push_back(mmu_weight_row);
            wb_col.push_back(mmu_weight_col);
        end
        if (mmu_input_valid === 1'b1) begin
            xb_data.push_back(mmu_input_data);
            xb_idx.push_back(mmu_input_index);
        end
        if (output_buf_wr_en === 1'b1) begin
            wr_addr.push_back(output_buf_wr_addr);
            wr_data.push_back(output_buf_wr_data);
        end
        if (done === 1'b1)  done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (busy === 1'b1)  busy_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic any_out();
        return |{busy, done, error, input_buf_rd_en, input_buf_rd_addr, weight_buf_rd_en,
                 weight_buf_rd_addr, output_buf_wr_en, output_buf_wr_addr, output_buf_wr_data,
                 mmu_weight_data, mmu_weight_row, mmu_weight_col, mmu_weight_valid,
                 mmu_input_data, mmu_input_index, mmu_input_valid};
    endfunction

    task automatic clear_mon();
        waddr_q.delete(); iaddr_q.delete();
        wb_data.delete(); wb_row.delete(); wb_col.delete();
        xb_data.delete(); xb_idx.delete();
        wr_addr.delete(); wr_data.delete();
        act_sent.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; rd_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (any_out() !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero while in reset, required all 0");
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_bad_dim(input logic [7:0] d);
        clear_mon();
        @(negedge clk); start = 1'b1; dim = d;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (err_cnt != 1 || busy_cnt != 0 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL bad_dim(%0d): errors=%0d busy_cycles=%0d reads=%0d, required 1 0 0",
                     d, err_cnt, busy_cnt, rd_cnt);
        end
    endtask

    task automatic test_spurious_valid();
        clear_mon();
        @(negedge clk); inj_wv = 1'b1; inj_iv = 1'b1;
        @(negedge clk); inj_wv = 1'b0; inj_iv = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (wb_data.size() != 0 || xb_data.size() != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL spurious_valid: weight_beats=%0d input_beats=%0d errors=%0d, required 0 0 0",
                     wb_data.size(), xb_data.size(), err_cnt);
        end
    endtask

    // Runs one full job of dimension n and checks every stream against the job model.
    task automatic run_job(input int n, input bit stray, input bit poke);
        int  cyc, gaps;
        bit  got;
        clear_mon();
        n_tb = n; resp_en = 1'b1;
        cyc = 0; gaps = 0; got = 1'b0;
        @(negedge clk); start = 1'b1; dim = 8'(n);
        @(negedge clk); start = 1'b0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            inj_act = 1'b0;
            start   = 1'b0;
            dim     = 8'(n);
            if (done === 1'b1) begin got = 1'b1; break; end
            if (busy !== 1'b1) gaps++;
            if (stray && cyc == 2) begin inj_act = 1'b1; inj_d = DW'($urandom); end
            if (poke && cyc == 3) begin start = 1'b1; dim = 8'((n == MD) ? 1 : n + 1); end
        end
        repeat (6) @(negedge clk);
        resp_en = 1'b0;

        n_tests++;
        if (!got) begin n_fail++; $display("FAIL job%0d_done_timeout: no done in %0d cycles", n, cyc); end
        n_tests++;
        if (gaps != 0) begin n_fail++; $display("FAIL job%0d_busy: busy low %0d cycles mid-job, required 0", n, gaps); end
        n_tests++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL job%0d_done_once: done pulses=%0d busy=%b, required 1 0", n, done_cnt, busy);
        end
        n_tests++;
        if (err_cnt != int'(stray)) begin
            n_fail++;
            $display("FAIL job%0d_errors: error pulses=%0d, required %0d", n, err_cnt, int'(stray));
        end

        n_tests++;
        if (waddr_q.size() != n*n || wb_data.size() != n*n) begin
            n_fail++;
            $display("FAIL job%0d_weight_count: reads=%0d beats=%0d, required %0d", n,
                     waddr_q.size(), wb_data.size(), n*n);
        end else begin
            for (int j = 0; j < n*n; j++) begin
                n_tests++;
                if (waddr_q[j] !== WAW'(j) || wb_data[j] !== wmem[j] ||
                    wb_row[j] !== IW'(j / n) || wb_col[j] !== IW'(j % n)) begin
                    n_fail++;
                    $display("FAIL job%0d_weight[%0d]: addr=%0d data=%h row=%0d col=%0d, required %0d %h %0d %0d",
                             n, j, waddr_q[j], wb_data[j], wb_row[j], wb_col[j], j, wmem[j], j / n, j % n);
                end
            end
        end

        n_tests++;
        if (iaddr_q.size() != n*n || xb_data.size() != n*n) begin
            n_fail++;
            $display("FAIL job%0d_input_count: reads=%0d beats=%0d, required %0d", n,
                     iaddr_q.size(), xb_data.size(), n*n);
        end else begin
            for (int j = 0; j < n*n; j++) begin
                n_tests++;
                if (iaddr_q[j] !== IAW'(j) || xb_data[j] !== imem[j] || xb_idx[j] !== IW'(j % n)) begin
                    n_fail++;
                    $display("FAIL job%0d_input[%0d]: addr=%0d data=%h index=%0d, required %0d %h %0d",
                             n, j, iaddr_q[j], xb_data[j], xb_idx[j], j, imem[j], j % n);
                end
            end
        end

        n_tests++;
        if (wr_addr.size() != n*n || act_sent.size() != n*n) begin
            n_fail++;
            $display("FAIL job%0d_write_count: writes=%0d act_beats=%0d, required %0d", n,
                     wr_addr.size(), act_sent.size(), n*n);
        end else begin
            for (int j = 0; j < n*n; j++) begin
                n_tests++;
                if (wr_addr[j] !== OAW'(j) || wr_data[j] !== act_sent[j]) begin
                    n_fail++;
                    $display("FAIL job%0d_write[%0d]: addr=%0d data=%h, required %0d %h",
                             n, j, wr_addr[j], wr_data[j], j, act_sent[j]);
                end
            end
        end
    endtask

    task automatic test_clear();
        int cyc, wr_snap, busy_snap;
        clear_mon();
        n_tb = 4; resp_en = 1'b1; cyc = 0;
        @(negedge clk); start = 1'b1; dim = 8'd4;
        @(negedge clk); start = 1'b0;
        while (wr_addr.size() < 5 && cyc < 5000) begin @(negedge clk); cyc++; end
        n_tests++;
        if (wr_addr.size() < 5) begin
            n_fail++;
            $display("FAIL clear_reach_drain: writes=%0d after %0d cycles, required 5", wr_addr.size(), cyc);
        end
        #1;
        wr_snap = wr_addr.size();
        clear = 1'b1; start = 1'b1; resp_en = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0;
        n_tests++;
        if ({busy, done, input_buf_rd_en, weight_buf_rd_en, mmu_weight_valid,
             mmu_input_valid, output_buf_wr_en} !== 7'b0) begin
            n_fail++;
            $display("FAIL clear_outputs: busy=%b done=%b rd_en=%b%b valids=%b%b wr_en=%b, required all 0",
                     busy, done, input_buf_rd_en, weight_buf_rd_en, mmu_weight_valid,
                     mmu_input_valid, output_buf_wr_en);
        end
        busy_snap = busy_cnt;
        repeat (20) @(negedge clk);
        n_tests++;
        if (done_cnt != 0 || wr_addr.size() != wr_snap || busy_cnt != busy_snap) begin
            n_fail++;
            $display("FAIL clear_quiet: done=%0d writes=%0d busy_cycles=%0d, required 0 %0d %0d",
                     done_cnt, wr_addr.size(), busy_cnt - busy_snap, wr_snap, 0);
        end
        run_job(4, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int cyc;
        clear_mon();
        n_tb = 3; resp_en = 1'b1; cyc = 0;
        @(negedge clk); start = 1'b1; dim = 8'd3;
        @(negedge clk); start = 1'b0;
        while (iaddr_q.size() < 2 && cyc < 5000) begin @(negedge clk); cyc++; end
        n_tests++;
        if (iaddr_q.size() < 2) begin
            n_fail++;
            $display("FAIL areset_reach_loadx: input reads=%0d, required >=2", iaddr_q.size());
        end
        #1 rst = 1'b1; resp_en = 1'b0;
        #1;
        n_tests++;
        if (any_out() !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_outputs: outputs not all 0 before next edge (busy=%b)", busy);
        end
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_abandon: done=%0d busy=%b, required 0 0", done_cnt, busy);
        end
        run_job(3, 1'b0, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) wmem[a] = DW'($urandom);
        for (int a = 0; a < 256; a++)  imem[a] = DW'($urandom);
        test_reset();
        test_bad_dim(8'd0);
        test_bad_dim(8'd9);
        test_bad_dim(8'd200);
        test_spurious_valid();
        run_job(2, 1'b0, 1'b0);
        run_job(MD, 1'b0, 1'b0);
        run_job(1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) run_job(int'($urandom_range(1, MD)), 1'b0, 1'b0);
        run_job(3, 1'b1, 1'b0);
        run_job(5, 1'b0, 1'b1);
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
